// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// State encoding, NOP word and PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: {instr, pc_plus4, valid}.
// Hold on !en, clear to a bubble on clr.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic        valid,
  output logic [31:0] instr_q,
  output logic [31:0] pc_plus4_q,
  output logic        valid_q
);

  localparam logic [64:0] BUBBLE = {NOP_INSTR, 32'h0, 1'b0};

  logic [64:0] r;

  assign {instr_q, pc_plus4_q, valid_q} = r;

  // Reset wins, then hold, then clear, then load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= BUBBLE;
    end else if (en) begin
      r <= clr ? BUBBLE : {instr, pc_plus4, valid};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, one-outstanding imem handshake,
// 1-entry stall buffer and IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] held;
  logic [31:0] tgt;
  logic [31:0] word;
  logic        xfer;
  logic        stall;
  logic        take;
  logic        load;

  // Next state / PC; a redirect always wins over stall_f.
  always_comb begin
    xfer    = imem_req & imem_ready;
    stall   = stall_f | stall_d;
    tgt     = {redirect_pc[31:2], 2'b00};
    state_n = state;
    pc_n    = pc;
    take    = 1'b0;
    load    = 1'b0;
    case (state)
      FETCH: begin
        if (redirect_valid) begin
          pc_n = tgt;
          if (imem_req && !xfer) state_n = DROP;
        end else if (xfer) begin
          if (stall) begin
            state_n = HOLD;
            take    = 1'b1;
          end else begin
            load = 1'b1;
            pc_n = pc + PC_INC;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_n = FETCH;
          pc_n    = tgt;
        end else if (!stall) begin
          state_n = FETCH;
          load    = 1'b1;
          pc_n    = pc + PC_INC;
        end
      end
      DROP: begin
        if (redirect_valid) pc_n = tgt;
        if (xfer) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    word = (state == HOLD) ? held : imem_rdata;
  end

  // FSM with registered request/address; DROP keeps the stale address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      held      <= NOP_INSTR;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      imem_req <= (state_n != HOLD);
      if (state_n != DROP) imem_addr <= pc_n;
      if (take) held <= imem_rdata;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (!stall_d),
    .clr       (flush_d | !load),
    .instr     (word),
    .pc_plus4  (pc + PC_INC),
    .valid     (1'b1),
    .instr_q   (instr_d),
    .pc_plus4_q(pc_plus4_d),
    .valid_q   (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: flag-based fetch model,
// per-cycle compare plus directed literal checks.
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ K;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_d       (instr_d),
    .pc_plus4_d    (pc_plus4_d),
    .valid_d       (valid_d)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: next program-order PC, a held word, a stale request.
  logic        m_ok = 1'b0;
  logic [31:0] m_pc, m_addr, m_hword;
  logic        m_req, m_held, m_stale;
  logic [31:0] e_instr, e_pc4;
  logic        e_valid;

  always @(posedge clk) begin : model
    logic        x, st, got;
    logic [31:0] t, gi, gp;
    if (!rst_n) begin
      m_ok = 1'b1;
      m_pc = 0; m_addr = 0; m_req = 0;
      m_held = 0; m_stale = 0; m_hword = 0;
      e_instr = 0; e_pc4 = 0; e_valid = 0;
    end else begin
      x   = m_req & imem_ready;
      st  = stall_f | stall_d;
      t   = {redirect_pc[31:2], 2'b00};
      got = 0; gi = 0; gp = 0;
      if (m_held) begin
        if (redirect_valid) begin
          m_held = 0; m_pc = t;
        end else if (!st) begin
          got = 1; gi = m_hword; gp = m_pc + 4;
          m_pc = m_pc + 4; m_held = 0;
        end
      end else if (m_stale) begin
        if (redirect_valid) m_pc = t;
        if (x) m_stale = 0;
      end else begin
        if (redirect_valid) begin
          m_pc = t;
          if (m_req && !x) m_stale = 1;
        end else if (x) begin
          if (st) begin
            m_held = 1; m_hword = m_addr ^ K;
          end else begin
            got = 1; gi = m_addr ^ K; gp = m_pc + 4;
            m_pc = m_pc + 4;
          end
        end
      end
      if (!stall_d) begin
        if (flush_d || !got) begin
          e_instr = 0; e_pc4 = 0; e_valid = 0;
        end else begin
          e_instr = gi; e_pc4 = gp; e_valid = 1;
        end
      end
      m_req = !m_held;
      if (!m_stale) m_addr = m_pc;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("instr_d", instr_d, e_instr);
      chk("pc_plus4_d", pc_plus4_d, e_pc4);
      chk("valid_d", {31'b0, valid_d}, {31'b0, e_valid});
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      if (m_req) chk("imem_addr", imem_addr, m_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {ready, stall_f, stall_d, flush_d, redirect}
  logic [4:0] tbl [16] = '{
    5'b10000, 5'b11000, 5'b01000, 5'b00001,
    5'b10000, 5'b00000, 5'b00001, 5'b00100,
    5'b10000, 5'b10100, 5'b10010, 5'b11100,
    5'b11101, 5'b10000, 5'b10000, 5'b00000
  };

  initial begin
    rst_n = 0; stall_f = 0; stall_d = 0; flush_d = 0;
    redirect_valid = 0; redirect_pc = 0; imem_ready = 1;
    repeat (3) step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, 32'h0);
    rst_n = 1;
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step();
    chk("w0", instr_d, 32'hA5A5_0000);
    chk("w0_pc4", pc_plus4_d, 32'h4);
    chk("w0_valid", {31'b0, valid_d}, 32'd1);
    chk("addr4", imem_addr, 32'h4);
    step();
    chk("w4", instr_d, 32'hA5A5_0004);
    chk("w4_pc4", pc_plus4_d, 32'h8);
    chk("addr8", imem_addr, 32'h8);
    imem_ready = 0;
    repeat (3) step();
    chk("wait_addr", imem_addr, 32'h8);
    chk("wait_instr", instr_d, 32'h0);
    chk("wait_valid", {31'b0, valid_d}, 32'd0);
    imem_ready = 1;
    step();
    chk("w8", instr_d, 32'hA5A5_0008);
    chk("w8_pc4", pc_plus4_d, 32'hC);
    step();
    chk("addr10", imem_addr, 32'h10);
    stall_f = 1; stall_d = 1;
    step();
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_instr1", instr_d, 32'hA5A5_000C);
    step();
    chk("hold_instr2", instr_d, 32'hA5A5_000C);
    stall_f = 0; stall_d = 0;
    step();
    chk("w10", instr_d, 32'hA5A5_0010);
    chk("w10_pc4", pc_plus4_d, 32'h14);
    chk("addr14", imem_addr, 32'h14);
    repeat (3) step();
    chk("addr20", imem_addr, 32'h20);
    imem_ready = 0; redirect_valid = 1; redirect_pc = 32'h400;
    step();
    redirect_valid = 0;
    chk("drop_addr1", imem_addr, 32'h20);
    step();
    chk("drop_addr2", imem_addr, 32'h20);
    imem_ready = 1;
    step();
    chk("addr400", imem_addr, 32'h400);
    chk("drop_valid", {31'b0, valid_d}, 32'd0);
    step();
    chk("w400", instr_d, 32'hA5A5_0400);
    chk("w400_pc4", pc_plus4_d, 32'h404);
    redirect_valid = 1; redirect_pc = 32'h26; flush_d = 1;
    step();
    chk("addr24", imem_addr, 32'h24);
    chk("flush1_valid", {31'b0, valid_d}, 32'd0);
    redirect_pc = 32'h100;
    step();
    chk("flush2_instr", instr_d, 32'h0);
    chk("addr100", imem_addr, 32'h100);
    redirect_valid = 0; flush_d = 0;
    step();
    chk("w100", instr_d, 32'hA5A5_0100);
    stall_d = 1;
    step();
    chk("hold2_req", {31'b0, imem_req}, 32'd0);
    rst_n = 0;
    step();
    chk("mrst_req", {31'b0, imem_req}, 32'd0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_pc4", pc_plus4_d, 32'h0);
    rst_n = 1; stall_d = 0;
    step();
    chk("mrst_first", imem_addr, 32'h0);
    step();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 0;
    chk("addr_fff8", imem_addr, 32'hFFFF_FFF8);
    step();
    chk("w_fff8", instr_d, 32'h5A5A_FFF8);
    step();
    chk("w_fffc", instr_d, 32'h5A5A_FFFC);
    chk("wrap_pc4", pc_plus4_d, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    redirect_pc = 32'h200;
    for (int i = 0; i < 16; i++) begin
      {imem_ready, stall_f, stall_d, flush_d, redirect_valid} = tbl[i];
      step();
    end
    {imem_ready, stall_f, stall_d, flush_d, redirect_valid} = 5'b10000;
    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
